// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the 9-bit core and its fetch sequencer.
//   - opcode constants (EXT prefix, HALT)
//   - core FSM state encoding as seen on the core_state bus
//   - fetch sequencer state encoding
// The sequencer states XREQ/XWAIT exist only when FETCH_EXT_PREFIX_EN is defined.
package proc_pkg;

   localparam logic [3:0] OP_EXT  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1101;

   typedef enum logic [1:0] {
      CORE_FETCH   = 2'b00,
      CORE_EXECUTE = 2'b01,
      CORE_MEM     = 2'b10,
      CORE_HALTED  = 2'b11
   } core_state_t;

   typedef enum logic [2:0] {
      FS_IDLE   = 3'd0,
      FS_REQ    = 3'd1,
      FS_WAIT   = 3'd2,
`ifdef FETCH_EXT_PREFIX_EN
      FS_XREQ   = 3'd3,
      FS_XWAIT  = 3'd4,
`endif
      FS_READY  = 3'd5,
      FS_HALTED = 3'd6
   } fetch_state_t;

   // True when a 9-bit instruction word carries the EXT prefix opcode.
   function automatic logic is_ext(input logic [8:0] word);
      return (word[8:5] == OP_EXT);
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the 9-bit core.
// Owns the fetch PC, reads instruction memory with a fixed latency, presents
// the instruction (instr/pc) to the core and stalls it via core_start until
// the instruction is ready. Follows core branches and stops on core_done.
//
// Parameters: RESET_PC (PC after reset), IMEM_LAT (memory read latency, 1..4).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   host_hold           host freeze, keeps the core stalled
//   imem_addr/rdata     instruction memory address (registered) / read data
//   core_state, core_pc_load, core_pc_target, core_done   core status inputs
//   core_start          high stalls the core
//   instr, pc           instruction presented to the core and its address
//   ext_valid/ext_data  EXT immediate strobe and value
//   halted              sequencer has stopped
// Build option: FETCH_EXT_PREFIX_EN enables two-word EXT prefix unpacking;
// without it opcode 1110 is an ordinary single-word instruction.
module fetch_ctrl
   import proc_pkg::*;
#(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned IMEM_LAT = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       host_hold,
   output logic [7:0] imem_addr,
   input  logic [8:0] imem_rdata,
   input  logic [1:0] core_state,
   input  logic       core_pc_load,
   input  logic [7:0] core_pc_target,
   input  logic       core_done,
   output logic       core_start,
   output logic [8:0] instr,
   output logic [7:0] pc,
   output logic       ext_valid,
   output logic [7:0] ext_data,
   output logic       halted
);

   // Wait counter reload: WAIT/XWAIT last IMEM_LAT cycles, the last one latches data.
   localparam logic [1:0] LAT_M1 = 2'(IMEM_LAT - 1);

   fetch_state_t state_q;
   logic [7:0]   fetch_pc_q;
   logic [7:0]   next_pc_d;
   logic [7:0]   imem_addr_q;
   logic [8:0]   instr_q;
   logic [7:0]   pc_q;
   logic [1:0]   wait_cnt_q;
   logic         core_start_q;
   logic         halted_q;
`ifdef FETCH_EXT_PREFIX_EN
   logic         ext_valid_q;
   logic [7:0]   ext_data_q;
`endif

   // Next fetch address once the core executes the presented instruction.
   always_comb begin
      next_pc_d = fetch_pc_q + 8'd1;
      if (core_pc_load) begin
         next_pc_d = core_pc_target;
      end
`ifdef FETCH_EXT_PREFIX_EN
      else if (is_ext(instr_q)) begin
         next_pc_d = fetch_pc_q + 8'd2;
      end
`endif
      else begin
         next_pc_d = fetch_pc_q + 8'd1;
      end
   end

   // Fetch sequencer FSM with all outputs registered.
   // pc_q (the core-visible PC) only moves together with instr_q, so both stay
   // stable through the core's MEM cycle even though fetch_pc_q already moved on.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= FS_IDLE;
         fetch_pc_q   <= RESET_PC;
         imem_addr_q  <= RESET_PC;
         instr_q      <= 9'h000;
         pc_q         <= RESET_PC;
         wait_cnt_q   <= 2'd0;
         core_start_q <= 1'b1;
         halted_q     <= 1'b0;
`ifdef FETCH_EXT_PREFIX_EN
         ext_valid_q  <= 1'b0;
         ext_data_q   <= 8'h00;
`endif
      end else begin
         // Stall by default; only states that end up in READY release the core.
         core_start_q <= 1'b1;
`ifdef FETCH_EXT_PREFIX_EN
         ext_valid_q  <= 1'b0;
`endif
         if (core_done) begin
            state_q  <= FS_HALTED;
            halted_q <= 1'b1;
         end else begin
            case (state_q)
               FS_IDLE: begin
                  if (!host_hold) begin
                     imem_addr_q <= fetch_pc_q;
                     state_q     <= FS_REQ;
                  end else begin
                     state_q     <= FS_IDLE;
                  end
               end
               FS_REQ: begin
                  wait_cnt_q <= LAT_M1;
                  state_q    <= FS_WAIT;
               end
               FS_WAIT: begin
                  if (wait_cnt_q == 2'd0) begin
                     instr_q <= imem_rdata;
                     pc_q    <= fetch_pc_q;
`ifdef FETCH_EXT_PREFIX_EN
                     if (is_ext(imem_rdata)) begin
                        // Data word address wraps modulo 256.
                        imem_addr_q <= fetch_pc_q + 8'd1;
                        state_q     <= FS_XREQ;
                     end else begin
                        core_start_q <= host_hold;
                        state_q      <= FS_READY;
                     end
`else
                     core_start_q <= host_hold;
                     state_q      <= FS_READY;
`endif
                  end else begin
                     wait_cnt_q <= wait_cnt_q - 2'd1;
                  end
               end
`ifdef FETCH_EXT_PREFIX_EN
               FS_XREQ: begin
                  wait_cnt_q <= LAT_M1;
                  state_q    <= FS_XWAIT;
               end
               FS_XWAIT: begin
                  if (wait_cnt_q == 2'd0) begin
                     ext_data_q   <= imem_rdata[7:0];
                     ext_valid_q  <= 1'b1;
                     core_start_q <= host_hold;
                     state_q      <= FS_READY;
                  end else begin
                     wait_cnt_q <= wait_cnt_q - 2'd1;
                  end
               end
`endif
               FS_READY: begin
                  if (core_state == CORE_EXECUTE) begin
                     fetch_pc_q  <= next_pc_d;
                     imem_addr_q <= next_pc_d;
                     state_q     <= FS_REQ;
                  end else begin
                     core_start_q <= host_hold;
                     state_q      <= FS_READY;
                  end
               end
               FS_HALTED: begin
                  halted_q <= 1'b1;
                  state_q  <= FS_HALTED;
               end
               default: begin
                  // Unreachable encoding: restart fetching from the current PC.
                  state_q <= FS_IDLE;
               end
            endcase
         end
      end
   end

   assign imem_addr  = imem_addr_q;
   assign instr      = instr_q;
   assign pc         = pc_q;
   assign core_start = core_start_q;
   assign halted     = halted_q;
`ifdef FETCH_EXT_PREFIX_EN
   assign ext_valid  = ext_valid_q;
   assign ext_data   = ext_data_q;
`else
   assign ext_valid  = 1'b0;
   assign ext_data   = 8'h00;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Two instances share one instruction memory image: lane 0 uses IMEM_LAT=1 and
// RESET_PC=8'h00, lane 1 uses IMEM_LAT=3 and RESET_PC=8'hFD (wraps through 8'hFF).
// A program-level model predicts fetched words, PCs, EXT data and latencies.
`timescale 1ns/1ps
module tb_fetch_ctrl;
   import proc_pkg::*;

   localparam int         LAT0 = 1;
   localparam int         LAT1 = 3;
   localparam logic [7:0] RPC0 = 8'h00;
   localparam logic [7:0] RPC1 = 8'hFD;
`ifdef FETCH_EXT_PREFIX_EN
   localparam bit EXT_ON = 1'b1;
`else
   localparam bit EXT_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic [1:0]      rst_n_v, hold_v, pload_v, done_v;
   logic [1:0]      cstart_v, extv_v, halted_v;
   logic [1:0][1:0] cstate_v;
   logic [1:0][7:0] ptgt_v, addr_v, pc_v, extd_v;
   logic [1:0][8:0] rdata_v, instr_v;
   logic [8:0] mem [256];
   logic [8:0] pipe0 [LAT0];
   logic [8:0] pipe1 [LAT1];
   logic [7:0] exp_pc [2];
   int compared = 0;
   int failed   = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RPC0), .IMEM_LAT(LAT0)) dut0 (
      .clk(clk), .reset_n(rst_n_v[0]), .host_hold(hold_v[0]),
      .imem_addr(addr_v[0]), .imem_rdata(rdata_v[0]), .core_state(cstate_v[0]),
      .core_pc_load(pload_v[0]), .core_pc_target(ptgt_v[0]), .core_done(done_v[0]),
      .core_start(cstart_v[0]), .instr(instr_v[0]), .pc(pc_v[0]),
      .ext_valid(extv_v[0]), .ext_data(extd_v[0]), .halted(halted_v[0]));

   fetch_ctrl #(.RESET_PC(RPC1), .IMEM_LAT(LAT1)) dut1 (
      .clk(clk), .reset_n(rst_n_v[1]), .host_hold(hold_v[1]),
      .imem_addr(addr_v[1]), .imem_rdata(rdata_v[1]), .core_state(cstate_v[1]),
      .core_pc_load(pload_v[1]), .core_pc_target(ptgt_v[1]), .core_done(done_v[1]),
      .core_start(cstart_v[1]), .instr(instr_v[1]), .pc(pc_v[1]),
      .ext_valid(extv_v[1]), .ext_data(extd_v[1]), .halted(halted_v[1]));

   // Instruction memory: data for an address appears LAT cycles after it is presented.
   always @(posedge clk) begin
      pipe0[0] <= mem[addr_v[0]];
      for (int k = 1; k < LAT0; k++) pipe0[k] <= pipe0[k-1];
      pipe1[0] <= mem[addr_v[1]];
      for (int k = 1; k < LAT1; k++) pipe1[k] <= pipe1[k-1];
   end
   assign rdata_v[0] = pipe0[LAT0-1];
   assign rdata_v[1] = pipe1[LAT1-1];

   // Reference model: a word is a two-word EXT prefix only when the option is built in.
   function automatic bit mdl_is_ext(input logic [7:0] a);
      return EXT_ON && (mem[a][8:5] == 4'b1110);
   endfunction

   function automatic int mdl_lat(input int lane, input logic [7:0] a);
      int l = (lane == 0) ? LAT0 : LAT1;
      return mdl_is_ext(a) ? (2 + 2 * l) : (1 + l);
   endfunction

   function automatic logic [7:0] mdl_next(input logic [7:0] a, input bit load, input logic [7:0] tgt);
      if (load) return tgt;
      return mdl_is_ext(a) ? (a + 8'd2) : (a + 8'd1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Assert reset (asynchronously), check reset values, release on the next negedge.
   task automatic do_reset(input int lane);
      logic [7:0] rpc = (lane == 0) ? RPC0 : RPC1;
      hold_v[lane] = 1'b0; done_v[lane] = 1'b0; pload_v[lane] = 1'b0;
      cstate_v[lane] = CORE_FETCH;
      rst_n_v[lane] = 1'b0;
      #1;
      chk("rst_pc", pc_v[lane], rpc);
      chk("rst_instr", instr_v[lane], 9'h000);
      chk("rst_ext_data", extd_v[lane], 8'h00);
      chk("rst_ext_valid", extv_v[lane], 1'b0);
      chk("rst_core_start", cstart_v[lane], 1'b1);
      chk("rst_halted", halted_v[lane], 1'b0);
      chk("rst_imem_addr", addr_v[lane], rpc);
      @(negedge clk);
      rst_n_v[lane] = 1'b1;
      exp_pc[lane] = rpc;
   endtask

   // Count edges until the core is released, then check what it is handed.
   task automatic wait_ready(input int lane, input int extra);
      int n = 0;
      logic [7:0] a = exp_pc[lane];
      bit x = mdl_is_ext(a);
      while (cstart_v[lane] && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, mdl_lat(lane, a) + extra);
      chk("instr", instr_v[lane], mem[a]);
      chk("pc", pc_v[lane], a);
      chk("ext_valid", extv_v[lane], x);
      if (x) chk("ext_data", extd_v[lane], mem[a + 8'd1][7:0]);
      else if (!EXT_ON) chk("ext_data_tied", extd_v[lane], 8'h00);
   endtask

   // One EXECUTE cycle; afterwards the new fetch address must be on imem_addr.
   task automatic execute(input int lane, input bit load, input logic [7:0] tgt);
      logic [7:0] old = exp_pc[lane];
      logic [7:0] nxt = mdl_next(old, load, tgt);
      cstate_v[lane] = CORE_EXECUTE; pload_v[lane] = load; ptgt_v[lane] = tgt;
      @(negedge clk);
      cstate_v[lane] = CORE_MEM; pload_v[lane] = 1'b0; ptgt_v[lane] = 8'($urandom);
      chk("ext_pulse_once", extv_v[lane], 1'b0);
      chk("next_addr", addr_v[lane], nxt);
      chk("start_after_exec", cstart_v[lane], 1'b1);
      chk("pc_held", pc_v[lane], old);
      exp_pc[lane] = nxt;
   endtask

   task automatic run_random(input int lane, input int n);
      for (int i = 0; i < n; i++) begin
         cstate_v[lane] = CORE_FETCH;
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("ready_park", cstart_v[lane], 1'b0);
         end
         execute(lane, ($urandom_range(0, 3) == 0), 8'($urandom));
         wait_ready(lane, 0);
      end
   endtask

   initial begin
      logic [7:0] halt_addr;
      rst_n_v = 2'b00; hold_v = 2'b00; pload_v = 2'b00; done_v = 2'b00;
      cstate_v = '0; ptgt_v = '0;
      for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
      mem[8'h00] = 9'h012; mem[8'h01] = 9'h025; mem[8'h02] = 9'h031;
      mem[8'h03] = 9'h1C2; mem[8'h04] = 9'h0A5;
      mem[8'hFD] = 9'h044; mem[8'hFE] = 9'h055; mem[8'hFF] = 9'h066;
      @(negedge clk);

      // Lane 0: straight-line program, EXT pair at 3/4, branch, then random flow.
      do_reset(0);
      wait_ready(0, 1);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      execute(0, 1'b1, 8'h10); wait_ready(0, 0);
      run_random(0, 20);
      // PC wrap with a plain word at 8'hFF, then an EXT at 8'hFF taking data from 8'h00.
      mem[8'hFF] = 9'h066;
      execute(0, 1'b1, 8'hFF); wait_ready(0, 0);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      mem[8'hFF] = 9'h1C7;
      execute(0, 1'b1, 8'hFF); wait_ready(0, 0);
      execute(0, 1'b0, 8'h00); wait_ready(0, 0);
      mem[8'hFF] = 9'h066;
      // HALT: sequencer freezes regardless of later core/host activity.
      halt_addr = mdl_is_ext(exp_pc[0]) ? (exp_pc[0] + 8'd1) : exp_pc[0];
      cstate_v[0] = CORE_EXECUTE; done_v[0] = 1'b1;
      @(negedge clk);
      done_v[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("halted", halted_v[0], 1'b1);
         chk("halt_start", cstart_v[0], 1'b1);
         chk("halt_addr", addr_v[0], halt_addr);
         cstate_v[0] = 2'($urandom); pload_v[0] = 1'($urandom);
         ptgt_v[0] = 8'($urandom); hold_v[0] = 1'($urandom);
         @(negedge clk);
      end

      // Lane 1: IMEM_LAT=3, reset PC near the top of the address space.
      do_reset(1);
      wait_ready(1, 1);
      execute(1, 1'b0, 8'h00);
      // host_hold raised mid-WAIT: the fetch still completes after 3 cycles.
      @(negedge clk);
      hold_v[1] = 1'b1;
      repeat (2) @(negedge clk);
      chk("hold_instr_old", instr_v[1], mem[8'hFD]);
      @(negedge clk);
      chk("hold_instr_new", instr_v[1], mem[8'hFE]);
      chk("hold_pc", pc_v[1], 8'hFE);
      for (int i = 0; i < 4; i++) begin
         chk("hold_start", cstart_v[1], 1'b1);
         @(negedge clk);
      end
      hold_v[1] = 1'b0;
      @(negedge clk);
      chk("hold_release", cstart_v[1], 1'b0);
      execute(1, 1'b0, 8'h00); wait_ready(1, 0);
      execute(1, 1'b0, 8'h00); wait_ready(1, 0);
      run_random(1, 10);
      // Reset in the middle of a fetch discards it and restarts from RESET_PC.
      execute(1, 1'b1, 8'h40);
      repeat (2) @(negedge clk);
      do_reset(1);
      wait_ready(1, 1);
      // core_done during WAIT halts on the next edge.
      execute(1, 1'b0, 8'h00);
      @(negedge clk);
      done_v[1] = 1'b1;
      @(negedge clk);
      done_v[1] = 1'b0;
      repeat (3) begin
         chk("halt_midfetch", halted_v[1], 1'b1);
         chk("halt_midfetch_start", cstart_v[1], 1'b1);
         @(negedge clk);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
